fpu_request_arbiter: RTL and testbench
======================================

FPU_REQUEST_ARBITER -- requirements
Module: fpu_request_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: number of WAIT cycles allowed before the arbiter aborts a datapath operation.
REQ-002 CLK  input  1  clock; all state changes on the rising edge.
REQ-003 RST  input  1  reset; synchronous and active-high.
REQ-004 REQn_VALID  input  1  requester n (n=0,1) has an operation pending.
REQ-005 REQn_READY  output  1  requester n's operation is accepted this cycle.
REQ-006 REQn_OP  input  2  requester n opcode: 00 add, 01 sub, 10 mul, 11 reserved.
REQ-007 REQn_A, REQn_B  input  8  requester n operands, 8-bit float format.
REQ-008 DP_START  output  1  one-cycle start pulse to the shared FPU datapath.
REQ-009 DP_OPERATION  output  2  opcode presented to the datapath.
REQ-010 DP_OP_A, DP_OP_B  output  8  operands presented to the datapath.
REQ-011 DP_DONE  input  1  datapath result valid.
REQ-012 DP_RESULT  input  8  datapath result.
REQ-013 RSP_VALID  output  1  one-cycle response pulse; no backpressure.
REQ-014 RSP_ID  output  1  requester the response belongs to.
REQ-015 RSP_RESULT  output  8  result value.
REQ-016 RSP_EXCEPTION  output  1  operation was not executed normally.
REQ-017 RSP_TIMEOUT  output  1  exception was caused by a datapath timeout.

Function
REQ-018 The arbiter SHALL use a four-state FSM: IDLE, ISSUE, WAIT, RESP.
REQ-019 In IDLE with at least one VALID, it SHALL grant one requester, assert only that requester's READY combinationally in that cycle, register its opcode and operands, and go to ISSUE.
REQ-020 Arbitration SHALL be round-robin: when both are valid, the requester other than the last granted wins; the last-grant pointer SHALL update on leaving RESP.
REQ-021 READY SHALL be 0 in every state other than IDLE.
REQ-022 In ISSUE, if the registered operands are an exception for the registered opcode, or the opcode is 11, the arbiter SHALL go to RESP with RSP_RESULT=_NAN, RSP_EXCEPTION=1, and no DP_START.
REQ-023 Otherwise, in ISSUE it SHALL pulse DP_START for exactly one cycle and go to WAIT.
REQ-024 DP_OPERATION, DP_OP_A and DP_OP_B SHALL hold the registered values from ISSUE until leaving WAIT.
REQ-025 Exception conditions:
- any opcode: either operand is _NAN;
- add: opposite-signed infinities;
- sub: both operands _PLUS_INF;
- mul: any infinity.
REQ-026 In WAIT, DP_DONE=1 SHALL latch DP_RESULT into RSP_RESULT with RSP_EXCEPTION=0 and go to RESP.
REQ-027 A cycle counter SHALL clear on entering WAIT and increment each WAIT cycle. If it reaches TIMEOUT-1 without DP_DONE, the arbiter SHALL go to RESP with RSP_RESULT=_NAN, RSP_EXCEPTION=1, RSP_TIMEOUT=1.
REQ-028 If DP_DONE and timeout occur in the same cycle, DP_DONE SHALL win.
REQ-029 DP_DONE SHALL be ignored outside WAIT.
REQ-030 In RESP, RSP_VALID SHALL be 1 for exactly one cycle with RSP_ID = the granted requester, then the FSM returns to IDLE.
REQ-031 RSP_RESULT, RSP_EXCEPTION, RSP_TIMEOUT and RSP_ID SHALL be registered and hold their values until the next RESP.
REQ-032 Latency from a READY cycle T: exception responses SHALL have RSP_VALID at T+2; normal responses SHALL have DP_START at T+1 and RSP_VALID one cycle after DP_DONE.
REQ-033 The next grant SHALL occur no earlier than the cycle after RESP.

Reset
REQ-034 RST=1 SHALL force state IDLE, the last-grant pointer to 1 (so REQ0 wins first), the counter to 0, and all outputs to 0, including in mid-operation.
REQ-035 After reset, no response SHALL be issued for an operation in flight before reset, and a later DP_DONE for it SHALL be ignored.

Structure
REQ-036 Opcode encodings (_ADDITION, _SUBTRACTION, _MULTIPLICATION) and special values (_NAN=8'h7C, _PLUS_INF=8'h78, _MINUS_INF=8'hF8) SHALL live in the shared FPU definitions include.
REQ-037 The FSM state encoding SHALL be local to the module.
REQ-038 Exception detection SHALL reuse the codebase's existing Exception_Module, instantiated once on the registered opcode and operands; opcode 11 is checked locally.

Verification
REQ-039 Single add: REQ0 add 8'h38+8'h38; DP_DONE 3 cycles after DP_START with 8'h40 -> READY0 at T, DP_START at T+1, RSP_VALID with ID=0, RESULT=8'h40, EXCEPTION=0.
REQ-040 Contention: both VALID from reset, held for two operations -> grants in order REQ0 then REQ1, with exactly one READY per grant.
REQ-041 Exception: REQ1 add 8'h78 with 8'hF8 -> no DP_START, RSP_VALID at T+2 with ID=1, RESULT=8'h7C, EXCEPTION=1; repeat with mul 8'h78 by 8'h38 and with opcode 11.
REQ-042 Timeout: DP_DONE never asserted -> RSP_VALID with EXCEPTION=1, TIMEOUT=1 after TIMEOUT WAIT cycles; a late DP_DONE is ignored.
REQ-043 Simultaneous events: DP_DONE on the final timeout cycle -> normal result, TIMEOUT=0.
REQ-044 Reset mid-WAIT: RST pulse, then DP_DONE -> no RSP_VALID, all outputs 0, and the next grant goes to REQ0.

Source files
------------

// File: rtl/fpu_request_arbiter_pkg.sv
// fpu_request_arbiter_pkg: shared FPU opcodes, special 8-bit float values and the request record
package fpu_request_arbiter_pkg;
    localparam logic [1:0] ADDITION       = 2'b00;
    localparam logic [1:0] SUBTRACTION    = 2'b01;
    localparam logic [1:0] MULTIPLICATION = 2'b10;
    localparam logic [1:0] RESERVED_OP    = 2'b11;
    localparam logic [7:0] NAN            = 8'h7C;
    localparam logic [7:0] PLUS_INF       = 8'h78;
    localparam logic [7:0] MINUS_INF      = 8'hF8;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } fpu_req_t;

    function automatic logic is_inf(input logic [7:0] x);
        return x == PLUS_INF || x == MINUS_INF;
    endfunction
endpackage

// File: rtl/fpu_request_arbiter_if.sv
// fpu_request_arbiter_if: two requesters, the shared datapath port and the response port
interface fpu_request_arbiter_if;
    logic [1:0]      req_valid_i;
    logic [1:0]      req_ready_o;
    logic [1:0][1:0] req_op_i;
    logic [1:0][7:0] req_a_i;
    logic [1:0][7:0] req_b_i;
    logic            dp_start_o;
    logic [1:0]      dp_operation_o;
    logic [7:0]      dp_op_a_o;
    logic [7:0]      dp_op_b_o;
    logic            dp_done_i;
    logic [7:0]      dp_result_i;
    logic            rsp_valid_o;
    logic            rsp_id_o;
    logic [7:0]      rsp_result_o;
    logic            rsp_exception_o;
    logic            rsp_timeout_o;

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, dp_done_i, dp_result_i,
        output req_ready_o, dp_start_o, dp_operation_o, dp_op_a_o, dp_op_b_o,
               rsp_valid_o, rsp_id_o, rsp_result_o, rsp_exception_o, rsp_timeout_o
    );
    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, dp_done_i, dp_result_i,
        input  req_ready_o, dp_start_o, dp_operation_o, dp_op_a_o, dp_op_b_o,
               rsp_valid_o, rsp_id_o, rsp_result_o, rsp_exception_o, rsp_timeout_o
    );
endinterface

// File: rtl/fpu_request_arbiter_exception.sv
// Exception_Module: flags operand/opcode combinations the datapath must not execute
module Exception_Module
    import fpu_request_arbiter_pkg::*;
(
    input  logic [1:0] op_i,
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic       exc_o
);
    always_comb begin
        exc_o = a_i == NAN || b_i == NAN
             || (op_i == ADDITION && is_inf(a_i) && is_inf(b_i) && a_i != b_i)
             || (op_i == SUBTRACTION && a_i == PLUS_INF && b_i == PLUS_INF)
             || (op_i == MULTIPLICATION && (is_inf(a_i) || is_inf(b_i)));
    end
endmodule

// File: rtl/fpu_request_arbiter.sv
// fpu_request_arbiter: round-robin arbiter sharing one FPU datapath between two requesters,
// with exception screening and a WAIT-state timeout
module fpu_request_arbiter
    import fpu_request_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fpu_request_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t   state_q;
    fpu_req_t req_q;
    logic     last_q, gnt_q, rsp_id_q, rsp_exc_q, rsp_to_q;
    logic [7:0]    rsp_result_q;
    logic [CW-1:0] cnt_q;
    logic gnt, exc, bad;

    // the requester that did not win last time takes priority on contention
    assign gnt = &bus.req_valid_i ? ~last_q : bus.req_valid_i[1];
    assign bad = exc || req_q.op == RESERVED_OP;

    Exception_Module u_exc (.op_i(req_q.op), .a_i(req_q.a), .b_i(req_q.b), .exc_o(exc));

    assign bus.req_ready_o     = (state_q == IDLE && |bus.req_valid_i && !rst) ? {gnt, ~gnt} : 2'b00;
    assign bus.dp_start_o      = state_q == ISSUE && !bad && !rst;
    assign bus.dp_operation_o  = req_q.op;
    assign bus.dp_op_a_o       = req_q.a;
    assign bus.dp_op_b_o       = req_q.b;
    assign bus.rsp_valid_o     = state_q == RESP && !rst;
    assign bus.rsp_id_o        = rsp_id_q;
    assign bus.rsp_result_o    = rsp_result_q;
    assign bus.rsp_exception_o = rsp_exc_q;
    assign bus.rsp_timeout_o   = rsp_to_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            gnt_q        <= 1'b0;
            req_q        <= '0;
            cnt_q        <= '0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_exc_q    <= 1'b0;
            rsp_to_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|bus.req_valid_i) begin
                    gnt_q   <= gnt;
                    req_q   <= '{op: bus.req_op_i[gnt], a: bus.req_a_i[gnt], b: bus.req_b_i[gnt]};
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    cnt_q <= '0;
                    if (bad) begin
                        rsp_id_q     <= gnt_q;
                        rsp_result_q <= NAN;
                        rsp_exc_q    <= 1'b1;
                        rsp_to_q     <= 1'b0;
                        state_q      <= RESP;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: if (bus.dp_done_i) begin
                    rsp_id_q     <= gnt_q;
                    rsp_result_q <= bus.dp_result_i;
                    rsp_exc_q    <= 1'b0;
                    rsp_to_q     <= 1'b0;
                    state_q      <= RESP;
                end else if (cnt_q == LAST) begin
                    rsp_id_q     <= gnt_q;
                    rsp_result_q <= NAN;
                    rsp_exc_q    <= 1'b1;
                    rsp_to_q     <= 1'b1;
                    state_q      <= RESP;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                RESP: begin
                    last_q  <= gnt_q;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_request_arbiter.sv
// tb_fpu_request_arbiter: scenario tasks plus randomized traffic checked against a
// transaction-level model of grant order, exception rules and response timing
module tb_fpu_request_arbiter;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic m_last;

    int         o_t_rdy, o_t_start, o_n_start, o_t_rsp, o_n_rsp, o_rdy_extra;
    logic [1:0] o_rdy, o_dp_op;
    logic [7:0] o_dp_a, o_dp_b, o_res;
    logic       o_id, o_exc, o_to;

    fpu_request_arbiter_if bus();
    fpu_request_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic model_exc(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bit a_inf = a[6:0] == 7'h78;
        bit b_inf = b[6:0] == 7'h78;
        if (op == 2'd3 || a == 8'h7C || b == 8'h7C) return 1'b1;
        if (op == 2'd0) return a_inf && b_inf && (a[7] != b[7]);
        if (op == 2'd1) return a == 8'h78 && b == 8'h78;
        return a_inf || b_inf;
    endfunction

    function automatic logic [7:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 8'h38;
            1: return 8'h40;
            2: return 8'h7C;
            3: return 8'h78;
            4: return 8'hF8;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid_i = 2'b00;
        bus.dp_done_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_req(input int n, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.req_op_i[n] = op;
        bus.req_a_i[n] = a;
        bus.req_b_i[n] = b;
    endtask

    // runs one grant-to-response transaction; dly is the DP_DONE offset from DP_START
    task automatic do_txn(input int dly, input logic [7:0] res, input bit drop);
        o_t_rdy = -1; o_t_start = -1; o_t_rsp = -1;
        o_n_start = 0; o_n_rsp = 0; o_rdy_extra = 0; o_rdy = 2'b00;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req_ready_o != 2'b00) begin
                o_t_rdy = cyc;
                o_rdy = bus.req_ready_o;
                break;
            end
            @(negedge clk);
        end
        if (o_t_rdy < 0) return;
        @(posedge clk);
        #1;
        if (drop) bus.req_valid_i = 2'b00;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            bus.dp_done_i = 1'b0;
            if (bus.dp_start_o) begin
                o_n_start++;
                if (o_t_start < 0) begin
                    o_t_start = cyc;
                    o_dp_op = bus.dp_operation_o;
                    o_dp_a = bus.dp_op_a_o;
                    o_dp_b = bus.dp_op_b_o;
                end
            end
            if (o_t_rsp < 0 && bus.req_ready_o != 2'b00) o_rdy_extra++;
            if (bus.rsp_valid_o) begin
                o_n_rsp++;
                if (o_t_rsp < 0) begin
                    o_t_rsp = cyc;
                    o_id = bus.rsp_id_o;
                    o_res = bus.rsp_result_o;
                    o_exc = bus.rsp_exception_o;
                    o_to = bus.rsp_timeout_o;
                end
            end
            if (o_t_start >= 0 && cyc == o_t_start + dly) begin
                bus.dp_done_i = 1'b1;
                bus.dp_result_i = res;
            end
            if (o_t_rsp >= 0 && (o_t_start < 0 || cyc > o_t_start + dly)) break;
        end
        bus.dp_done_i = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid_i = 2'b11;
        set_req(0, 2'd0, 8'h38, 8'h38);
        set_req(1, 2'd2, 8'h40, 8'h40);
        bus.dp_done_i = 1'b1;
        bus.dp_result_i = 8'hAA;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (bus.req_ready_o !== 2'b00 || bus.dp_start_o !== 1'b0 || bus.rsp_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got ready=%b start=%b rsp=%b want 00 0 0", bus.req_ready_o, bus.dp_start_o, bus.rsp_valid_o);
        end
        n_cmp++;
        if ({bus.rsp_id_o, bus.rsp_result_o, bus.rsp_exception_o, bus.rsp_timeout_o, bus.dp_operation_o, bus.dp_op_a_o, bus.dp_op_b_o} !== 29'd0) begin
            n_bad++;
            $display("FAIL reset_data: got id=%b res=%h exc=%b to=%b op=%h a=%h b=%h want all 0", bus.rsp_id_o, bus.rsp_result_o,
                     bus.rsp_exception_o, bus.rsp_timeout_o, bus.dp_operation_o, bus.dp_op_a_o, bus.dp_op_b_o);
        end
        bus.req_valid_i = 2'b00;
        bus.dp_done_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_add();
        set_req(0, 2'd0, 8'h38, 8'h38);
        bus.req_valid_i = 2'b01;
        do_txn(3, 8'h40, 1'b1);
        n_cmp++;
        if (o_rdy !== 2'b01) begin n_bad++; $display("FAIL add_ready: got %b want 01", o_rdy); end
        n_cmp++;
        if (o_t_start != o_t_rdy + 1 || o_n_start != 1) begin
            n_bad++; $display("FAIL add_start: got t=%0d n=%0d want t=%0d n=1", o_t_start, o_n_start, o_t_rdy + 1);
        end
        n_cmp++;
        if (o_t_rsp != o_t_start + 4 || o_n_rsp != 1) begin
            n_bad++; $display("FAIL add_rsp_time: got t=%0d n=%0d want t=%0d n=1", o_t_rsp, o_n_rsp, o_t_start + 4);
        end
        n_cmp++;
        if ({o_id, o_res, o_exc, o_to} !== {1'b0, 8'h40, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL add_rsp: got id=%b res=%h exc=%b to=%b want 0 40 0 0", o_id, o_res, o_exc, o_to);
        end
        n_cmp++;
        if ({o_dp_op, o_dp_a, o_dp_b} !== {2'd0, 8'h38, 8'h38}) begin
            n_bad++; $display("FAIL add_dp: got op=%h a=%h b=%h want 0 38 38", o_dp_op, o_dp_a, o_dp_b);
        end
    endtask

    task automatic test_contention();
        do_reset();
        set_req(0, 2'd0, 8'h38, 8'h40);
        set_req(1, 2'd1, 8'h40, 8'h38);
        bus.req_valid_i = 2'b11;
        for (int k = 0; k < 2; k++) begin
            do_txn(2, 8'h11 + 8'(k), 1'b0);
            n_cmp++;
            if (o_rdy !== (k == 0 ? 2'b01 : 2'b10) || o_rdy_extra != 0) begin
                n_bad++; $display("FAIL contention_ready%0d: got %b extra=%0d want %b extra=0", k, o_rdy, o_rdy_extra, k == 0 ? 2'b01 : 2'b10);
            end
            n_cmp++;
            if (o_id !== 1'(k) || o_res !== 8'h11 + 8'(k) || o_t_rsp != o_t_start + 3) begin
                n_bad++; $display("FAIL contention_rsp%0d: got id=%b res=%h t=%0d want %0d %h %0d", k, o_id, o_res, o_t_rsp,
                                  k, 8'h11 + 8'(k), o_t_start + 3);
            end
        end
        bus.req_valid_i = 2'b00;
    endtask

    task automatic test_exception();
        logic [17:0] cases [3];
        cases[0] = {2'd0, 8'h78, 8'hF8};
        cases[1] = {2'd2, 8'h78, 8'h38};
        cases[2] = {2'd3, 8'h38, 8'h38};
        for (int k = 0; k < 3; k++) begin
            set_req(1, cases[k][17:16], cases[k][15:8], cases[k][7:0]);
            bus.req_valid_i = 2'b10;
            do_txn(3, 8'h55, 1'b1);
            n_cmp++;
            if (o_rdy !== 2'b10 || o_n_start != 0 || o_t_rsp != o_t_rdy + 2) begin
                n_bad++; $display("FAIL exc%0d_timing: got ready=%b starts=%0d t=%0d want 10 0 %0d", k, o_rdy, o_n_start, o_t_rsp, o_t_rdy + 2);
            end
            n_cmp++;
            if ({o_id, o_res, o_exc, o_to} !== {1'b1, 8'h7C, 1'b1, 1'b0}) begin
                n_bad++; $display("FAIL exc%0d_rsp: got id=%b res=%h exc=%b to=%b want 1 7c 1 0", k, o_id, o_res, o_exc, o_to);
            end
        end
    endtask

    task automatic test_timeout();
        int extra = 0;
        set_req(0, 2'd0, 8'h38, 8'h40);
        bus.req_valid_i = 2'b01;
        do_txn(TO + 1, 8'h66, 1'b1);
        n_cmp++;
        if (o_t_rsp != o_t_start + TO + 1 || o_n_rsp != 1) begin
            n_bad++; $display("FAIL timeout_time: got t=%0d n=%0d want t=%0d n=1", o_t_rsp, o_n_rsp, o_t_start + TO + 1);
        end
        n_cmp++;
        if ({o_res, o_exc, o_to} !== {8'h7C, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL timeout_rsp: got res=%h exc=%b to=%b want 7c 1 1", o_res, o_exc, o_to);
        end
        for (int i = 0; i < 3; i++) begin
            bus.dp_done_i = 1'b1;
            bus.dp_result_i = 8'h22;
            @(negedge clk);
            if (bus.rsp_valid_o) extra++;
        end
        bus.dp_done_i = 1'b0;
        n_cmp++;
        if (extra != 0 || bus.rsp_result_o !== 8'h7C || bus.rsp_timeout_o !== 1'b1) begin
            n_bad++; $display("FAIL timeout_late_done: got extra=%0d res=%h to=%b want 0 7c 1", extra, bus.rsp_result_o, bus.rsp_timeout_o);
        end
    endtask

    task automatic test_simultaneous();
        set_req(1, 2'd2, 8'h40, 8'h38);
        bus.req_valid_i = 2'b10;
        do_txn(TO, 8'h5A, 1'b1);
        n_cmp++;
        if (o_t_rsp != o_t_start + TO + 1 || {o_res, o_exc, o_to} !== {8'h5A, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL simultaneous: got t=%0d res=%h exc=%b to=%b want t=%0d 5a 0 0", o_t_rsp, o_res, o_exc, o_to, o_t_start + TO + 1);
        end
    endtask

    task automatic test_reset_mid_wait();
        int seen = 0;
        set_req(0, 2'd1, 8'h40, 8'h38);
        bus.req_valid_i = 2'b01;
        do_txn(2, 8'h33, 1'b1);
        bus.req_valid_i = 2'b01;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.req_ready_o != 2'b00) break;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.req_valid_i = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.dp_done_i = i < 2;
            bus.dp_result_i = 8'h44;
            @(negedge clk);
            if (bus.rsp_valid_o || bus.dp_start_o) seen++;
        end
        bus.dp_done_i = 1'b0;
        n_cmp++;
        if (seen != 0) begin n_bad++; $display("FAIL midreset_no_rsp: got %0d pulses want 0", seen); end
        n_cmp++;
        if ({bus.rsp_id_o, bus.rsp_result_o, bus.rsp_exception_o, bus.rsp_timeout_o, bus.dp_operation_o, bus.dp_op_a_o, bus.dp_op_b_o} !== 29'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got id=%b res=%h exc=%b to=%b op=%h a=%h b=%h want all 0", bus.rsp_id_o, bus.rsp_result_o,
                     bus.rsp_exception_o, bus.rsp_timeout_o, bus.dp_operation_o, bus.dp_op_a_o, bus.dp_op_b_o);
        end
        bus.req_valid_i = 2'b11;
        do_txn(2, 8'h12, 1'b1);
        n_cmp++;
        if (o_rdy !== 2'b01 || o_id !== 1'b0) begin
            n_bad++; $display("FAIL midreset_grant: got ready=%b id=%b want 01 0", o_rdy, o_id);
        end
    endtask

    task automatic test_random();
        do_reset();
        m_last = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [1:0] pat = 2'($urandom_range(1, 3));
            int dly = $urandom_range(1, TO + 1);
            logic [7:0] res = 8'($urandom);
            logic g;
            logic [1:0] op;
            logic [7:0] a, b;
            logic e;
            int t_exp;
            for (int n = 0; n < 2; n++) set_req(n, 2'($urandom_range(0, 3)), pick_val(), pick_val());
            g = (pat == 2'b11) ? ~m_last : pat[1];
            op = bus.req_op_i[g];
            a = bus.req_a_i[g];
            b = bus.req_b_i[g];
            e = model_exc(op, a, b);
            bus.req_valid_i = pat;
            do_txn(dly, res, 1'b1);
            m_last = g;
            n_cmp++;
            if (o_rdy !== {g, ~g} || o_id !== g) begin
                n_bad++; $display("FAIL rand%0d_grant: got ready=%b id=%b want grant %0d", k, o_rdy, o_id, g);
            end
            t_exp = e ? o_t_rdy + 2 : o_t_rdy + 2 + (dly < TO ? dly : TO);
            n_cmp++;
            if (o_t_rsp != t_exp || o_n_start != (e ? 0 : 1) || o_n_rsp != 1) begin
                n_bad++; $display("FAIL rand%0d_timing: got t=%0d starts=%0d rsps=%0d want t=%0d starts=%0d rsps=1", k, o_t_rsp,
                                  o_n_start, o_n_rsp, t_exp, e ? 0 : 1);
            end
            n_cmp++;
            if (e ? {o_res, o_exc, o_to} !== {8'h7C, 1'b1, 1'b0}
                  : dly <= TO ? {o_res, o_exc, o_to} !== {res, 1'b0, 1'b0} : {o_res, o_exc, o_to} !== {8'h7C, 1'b1, 1'b1}) begin
                n_bad++; $display("FAIL rand%0d_result: got res=%h exc=%b to=%b for op=%0d a=%h b=%h dly=%0d done=%h", k, o_res, o_exc,
                                  o_to, op, a, b, dly, res);
            end
            if (!e) begin
                n_cmp++;
                if ({o_dp_op, o_dp_a, o_dp_b} !== {op, a, b}) begin
                    n_bad++; $display("FAIL rand%0d_dp: got op=%h a=%h b=%h want %h %h %h", k, o_dp_op, o_dp_a, o_dp_b, op, a, b);
                end
            end
        end
    endtask

    initial begin
        bus.req_valid_i = 2'b00;
        bus.req_op_i = '0;
        bus.req_a_i = '0;
        bus.req_b_i = '0;
        bus.dp_done_i = 1'b0;
        bus.dp_result_i = 8'h00;
        test_reset();
        test_single_add();
        test_contention();
        test_exception();
        test_timeout();
        test_simultaneous();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
